// File: rtl/port_match_collector_pkg.sv
// Shared types and constants for the port-group unit and its downstream collector.
// PMC_PU_LATENCY must track the port-unit pipeline depth.
package port_match_collector_pkg;

    localparam int PG_AWIDTH      = 8;
    localparam int PMC_PU_LATENCY = 12;
    localparam int PMC_RULE_WIDTH = 16;

    typedef struct packed {
        logic [15:0] src_lo;
        logic [15:0] src_hi;
        logic [15:0] dst_lo;
        logic [15:0] dst_hi;
        logic        tcp_en;
        logic        udp_en;
    } pg_entry_t;

    typedef struct packed {
        logic [PMC_RULE_WIDTH-1:0] rule;
        logic                      hit;
        logic                      last;
    } pmc_entry_t;

endpackage

// File: rtl/port_match_collector_fifo.sv
// pmc_fifo: show-ahead synchronous FIFO of collector entries with an occupancy count.
// Head data reads as zero while empty so the outputs are clean straight out of reset.
module pmc_fifo
    import port_match_collector_pkg::*;
#(
    parameter type entry_t = pmc_entry_t,
    parameter int  DEPTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output entry_t                 head_o,
    output logic                   head_valid_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          empty, full, pop_ok;

    assign empty  = (count_q == '0);
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign pop_ok = pop_i & ~empty;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_i && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o       = empty ? '0 : mem_q[rd_ptr_q];
    assign head_valid_o = ~empty;
    assign count_o      = count_q;

    // Credit admission upstream makes this unreachable; flag it if that ever breaks.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/port_match_collector.sv
// port_match_collector: issues candidates to the port unit, re-aligns port_match through a
// fixed delay line and queues results with credit admission. Optional counters: PMC_STATS_EN.
module port_match_collector
    import port_match_collector_pkg::*;
#(
    parameter int RULE_WIDTH = 16,
    parameter int PU_LATENCY = PMC_PU_LATENCY,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RULE_WIDTH-1:0] in_rule_data,
    input  logic [PG_AWIDTH-1:0]  in_rule_pg,
    input  logic [15:0]           in_src_port,
    input  logic [15:0]           in_dst_port,
    input  logic                  in_tcp,
    input  logic                  in_rule_last,
    input  logic                  in_rule_valid,
    output logic                  in_rule_ready,
    output logic [PG_AWIDTH-1:0]  pu_pg,
    output logic                  pu_pg_valid,
    output logic [15:0]           pu_src_port,
    output logic [15:0]           pu_dst_port,
    output logic                  pu_tcp,
    input  logic                  pu_port_match,
    output logic [RULE_WIDTH-1:0] out_rule_data,
    output logic                  out_rule_hit,
    output logic                  out_rule_last,
    output logic                  out_rule_valid,
    input  logic                  out_rule_ready,
    output logic [31:0]           stat_rules_in,
    output logic [31:0]           stat_rules_hit
);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int CREDIT_W = $clog2(FIFO_DEPTH + PU_LATENCY + 2);

    typedef struct packed {
        logic [RULE_WIDTH-1:0] rule;
        logic                  hit;
        logic                  last;
    } rule_entry_t;

    logic                  accept, retire, push;
    logic [CNT_W-1:0]      fifo_count;
    logic [CREDIT_W-1:0]   inflight_q, inflight_d, credit_used;
    rule_entry_t           push_entry, head_entry;

    logic                  pu_pg_valid_q;
    logic [PG_AWIDTH-1:0]  pu_pg_q;
    logic [15:0]           pu_src_q, pu_dst_q;
    logic                  pu_tcp_q;
    logic [RULE_WIDTH-1:0] issue_rule_q;
    logic                  issue_last_q;

    assign credit_used   = CREDIT_W'(fifo_count) + inflight_q;
    assign in_rule_ready = (credit_used < CREDIT_W'(FIFO_DEPTH));
    assign accept        = in_rule_valid & in_rule_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pu_pg_valid_q <= 1'b0;
            pu_pg_q       <= '0;
            pu_src_q      <= '0;
            pu_dst_q      <= '0;
            pu_tcp_q      <= 1'b0;
            issue_rule_q  <= '0;
            issue_last_q  <= 1'b0;
        end else begin
            pu_pg_valid_q <= accept;
            if (accept) begin
                pu_pg_q      <= in_rule_pg;
                pu_src_q     <= in_src_port;
                pu_dst_q     <= in_dst_port;
                pu_tcp_q     <= in_tcp;
                issue_rule_q <= in_rule_data;
                issue_last_q <= in_rule_last;
            end
        end
    end

    assign pu_pg_valid = pu_pg_valid_q;
    assign pu_pg       = pu_pg_q;
    assign pu_src_port = pu_src_q;
    assign pu_dst_port = pu_dst_q;
    assign pu_tcp      = pu_tcp_q;

    // Stage 0 captures the issue register on the same edge the port unit samples it,
    // so the last stage lines up with pu_port_match.
    logic [PU_LATENCY-1:0] dl_valid_q, dl_valid_d;
    logic [PU_LATENCY-1:0] dl_last_q, dl_last_d;
    logic [RULE_WIDTH-1:0] dl_rule_q [PU_LATENCY];
    logic [RULE_WIDTH-1:0] dl_rule_d [PU_LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < PU_LATENCY; gi++) begin : g_dl
            if (gi == 0) begin : g_head
                assign dl_valid_d[gi] = pu_pg_valid_q;
                assign dl_last_d[gi]  = issue_last_q;
                assign dl_rule_d[gi]  = issue_rule_q;
            end else begin : g_tail
                assign dl_valid_d[gi] = dl_valid_q[gi-1];
                assign dl_last_d[gi]  = dl_last_q[gi-1];
                assign dl_rule_d[gi]  = dl_rule_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid_q <= '0;
        end else begin
            dl_valid_q <= dl_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        dl_last_q <= dl_last_d;
        dl_rule_q <= dl_rule_d;
    end

    assign retire          = dl_valid_q[PU_LATENCY-1];
    assign push            = retire & (pu_port_match | dl_last_q[PU_LATENCY-1]);
    assign push_entry.rule = dl_rule_q[PU_LATENCY-1];
    assign push_entry.hit  = pu_port_match;
    assign push_entry.last = dl_last_q[PU_LATENCY-1];

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !retire) begin
            inflight_d = inflight_q + CREDIT_W'(1);
        end else if (!accept && retire) begin
            inflight_d = inflight_q - CREDIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    pmc_fifo #(
        .entry_t (rule_entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (out_rule_ready),
        .head_o       (head_entry),
        .head_valid_o (out_rule_valid),
        .count_o      (fifo_count)
    );

    assign out_rule_data = head_entry.rule;
    assign out_rule_hit  = head_entry.hit;
    assign out_rule_last = head_entry.last;

`ifdef PMC_STATS_EN
    logic [31:0] stat_in_q, stat_hit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_in_q  <= '0;
            stat_hit_q <= '0;
        end else begin
            if (accept) begin
                stat_in_q <= stat_in_q + 32'd1;
            end
            if (push && pu_port_match) begin
                stat_hit_q <= stat_hit_q + 32'd1;
            end
        end
    end

    assign stat_rules_in  = stat_in_q;
    assign stat_rules_hit = stat_hit_q;
`else
    assign stat_rules_in  = '0;
    assign stat_rules_hit = '0;
`endif

endmodule

// File: tb/tb_port_match_collector.sv
// Self-checking bench for port_match_collector: fixed-latency port-unit model, scoreboard
// of expected FIFO entries, and a timing-based credit model checked every cycle.
`timescale 1ns/1ps
module tb_port_match_collector;
    import port_match_collector_pkg::*;

    localparam int RW    = 16;
    localparam int L     = 12;
    localparam int DEPTH = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [RW-1:0]        in_rule_data = '0;
    logic [PG_AWIDTH-1:0] in_rule_pg = '0;
    logic [15:0]          in_src_port = '0;
    logic [15:0]          in_dst_port = '0;
    logic                 in_tcp = 1'b0;
    logic                 in_rule_last = 1'b0;
    logic                 in_rule_valid = 1'b0;
    logic                 in_rule_ready;
    logic [PG_AWIDTH-1:0] pu_pg;
    logic                 pu_pg_valid;
    logic [15:0]          pu_src_port, pu_dst_port;
    logic                 pu_tcp;
    logic                 pu_port_match;
    logic [RW-1:0]        out_rule_data;
    logic                 out_rule_hit, out_rule_last, out_rule_valid;
    logic                 out_rule_ready = 1'b0;
    logic [31:0]          stat_rules_in, stat_rules_hit;

    port_match_collector #(
        .RULE_WIDTH (RW),
        .PU_LATENCY (L),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_rule_data   (in_rule_data),
        .in_rule_pg     (in_rule_pg),
        .in_src_port    (in_src_port),
        .in_dst_port    (in_dst_port),
        .in_tcp         (in_tcp),
        .in_rule_last   (in_rule_last),
        .in_rule_valid  (in_rule_valid),
        .in_rule_ready  (in_rule_ready),
        .pu_pg          (pu_pg),
        .pu_pg_valid    (pu_pg_valid),
        .pu_src_port    (pu_src_port),
        .pu_dst_port    (pu_dst_port),
        .pu_tcp         (pu_tcp),
        .pu_port_match  (pu_port_match),
        .out_rule_data  (out_rule_data),
        .out_rule_hit   (out_rule_hit),
        .out_rule_last  (out_rule_last),
        .out_rule_valid (out_rule_valid),
        .out_rule_ready (out_rule_ready),
        .stat_rules_in  (stat_rules_in),
        .stat_rules_hit (stat_rules_hit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    logic [RW+1:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pu_fn(input logic [PG_AWIDTH-1:0] pg, input logic [15:0] s,
                                   input logic [15:0] d, input logic t);
        return pg[0] ^ t ^ s[3] ^ d[5];
    endfunction

    // Port unit: not reset, fixed L-cycle pipeline from sampled pu_pg_valid to pu_port_match.
    logic [L-1:0] pu_pipe = '0;
    logic         force_match = 1'b0;
    always @(posedge clk) begin
        pu_pipe <= {pu_pipe[L-2:0],
                    force_match | (pu_pg_valid & pu_fn(pu_pg, pu_src_port, pu_dst_port, pu_tcp))};
    end
    assign pu_port_match = pu_pipe[L-1];

    // Credit model: an accept at edge e retires at edge e+L+1 and pushes if match or last.
    int          m_inflight = 0;
    int          m_count = 0;
    logic [63:0] m_rv = '0;
    logic [63:0] m_rp = '0;
    logic [5:0]  m_e = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_inflight <= 0;
            m_count    <= 0;
            m_rv       <= '0;
            m_e        <= '0;
        end else begin
            m_e        <= m_e + 6'd1;
            m_inflight <= m_inflight + int'(in_rule_valid && in_rule_ready) - int'(m_rv[m_e]);
            m_count    <= m_count + int'(m_rv[m_e] && m_rp[m_e])
                                  - int'((m_count != 0) && out_rule_ready);
            m_rv[m_e]  <= 1'b0;
            if (in_rule_valid && in_rule_ready) begin
                m_rv[m_e + 6'(L+1)] <= 1'b1;
                m_rp[m_e + 6'(L+1)] <= in_rule_last |
                                       pu_fn(in_rule_pg, in_src_port, in_dst_port, in_tcp);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("credit_ready", in_rule_ready, (m_count + m_inflight) < DEPTH);
            chk("fifo_valid", out_rule_valid, m_count != 0);
            if (out_rule_valid && out_rule_ready) begin
                n_pop++;
                $display("[%0t] pop rule=%h hit=%b last=%b", $time,
                         out_rule_data, out_rule_hit, out_rule_last);
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    chk("out_entry", {out_rule_data, out_rule_hit, out_rule_last}, sb.pop_front());
                end
            end
        end
    end

    task automatic expect_beat(input logic [RW-1:0] r, input logic [PG_AWIDTH-1:0] pg,
                               input logic [15:0] s, input logic [15:0] d,
                               input logic t, input logic lst);
        logic m;
        m = pu_fn(pg, s, d, t);
        if (m || lst) sb.push_back({r, m, lst});
    endtask

    task automatic send(input logic [RW-1:0] r, input logic [PG_AWIDTH-1:0] pg,
                        input logic [15:0] s, input logic [15:0] d,
                        input logic t, input logic lst);
        int w = 0;
        in_rule_data = r; in_rule_pg = pg; in_src_port = s; in_dst_port = d;
        in_tcp = t; in_rule_last = lst; in_rule_valid = 1'b1;
        while (!in_rule_ready && w < 500) begin
            @(posedge clk); #1; w++;
        end
        chk("send_credit_wait", w < 500, 1'b1);
        if (w < 500) expect_beat(r, pg, s, d, t, lst);
        @(posedge clk); #1;
        in_rule_valid = 1'b0;
        $display("[%0t] sent rule=%h pg=%h last=%b", $time, r, pg, lst);
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (sb.size() != 0 && w < 3000) begin
            @(posedge clk); #1; w++;
        end
        repeat (L + 4) begin @(posedge clk); #1; end
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acc, p0, seen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", in_rule_ready, 1'b1);
        chk("rst_pu_valid", pu_pg_valid, 1'b0);
        chk("rst_pu_fields", {pu_pg, pu_src_port, pu_dst_port, pu_tcp}, '0);
        chk("rst_out_valid", out_rule_valid, 1'b0);
        chk("rst_out_data", {out_rule_data, out_rule_hit, out_rule_last}, '0);
        chk("rst_stats", {stat_rules_in, stat_rules_hit}, '0);
        @(posedge clk); #1;

        // Single matching rule: latency and content
        out_rule_ready = 1'b1;
        send(16'h0A11, 8'h01, 16'h0000, 16'h0000, 1'b0, 1'b1);
        n = 0;
        while (!out_rule_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("t1_latency", n, L + 1);
        chk("t1_head", {out_rule_data, out_rule_hit, out_rule_last}, {16'h0A11, 1'b1, 1'b1});
        drain("t1_drain");

        // Packet of three, matches 0/1/0, last on the third
        p0 = n_pop;
        send(16'h0B00, 8'h02, 16'h0000, 16'h0000, 1'b0, 1'b0);
        send(16'h0B01, 8'h03, 16'h0000, 16'h0000, 1'b0, 1'b0);
        send(16'h0B02, 8'h04, 16'h0000, 16'h0000, 1'b0, 1'b1);
        drain("t2_drain");
        chk("t2_entries", n_pop - p0, 2);

        // Back-pressure: continuous matching input with the output stalled
        out_rule_ready = 1'b0;
        acc = 0;
        in_rule_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            in_rule_data = 16'h1000 + 16'(acc); in_rule_pg = 8'h01;
            in_src_port = '0; in_dst_port = '0; in_tcp = 1'b0; in_rule_last = 1'b0;
            if (in_rule_ready) begin
                expect_beat(in_rule_data, in_rule_pg, in_src_port, in_dst_port, in_tcp, in_rule_last);
                acc++;
            end
            @(posedge clk); #1;
        end
        in_rule_valid = 1'b0;
        chk("t3_accepts", acc, DEPTH);
        chk("t3_ready_low", in_rule_ready, 1'b0);
        chk("t3_head_valid", out_rule_valid, 1'b1);
        p0 = n_pop;
        out_rule_ready = 1'b1;
        drain("t3_drain");
        chk("t3_drained", n_pop - p0, DEPTH);
        chk("t3_ready_back", in_rule_ready, 1'b1);

        // Random traffic around the credit boundary
        for (int c = 0; c < 1000; c++) begin
            in_rule_valid = ($urandom_range(0, 9) < 7);
            in_rule_data = RW'($urandom);
            in_rule_pg = PG_AWIDTH'($urandom);
            in_src_port = 16'($urandom);
            in_dst_port = 16'($urandom);
            in_tcp = 1'($urandom_range(0, 1));
            in_rule_last = ($urandom_range(0, 3) == 0);
            out_rule_ready = 1'($urandom_range(0, 1));
            if (in_rule_valid && in_rule_ready) begin
                expect_beat(in_rule_data, in_rule_pg, in_src_port, in_dst_port, in_tcp, in_rule_last);
            end
            @(posedge clk); #1;
        end
        in_rule_valid = 1'b0;
        out_rule_ready = 1'b1;
        drain("t4_drain");
        chk("t4_ready_idle", in_rule_ready, 1'b1);

        // Reset with rules in flight while the port unit keeps reporting matches
        for (int i = 0; i < 5; i++) send(16'h2000 + 16'(i), 8'h01, '0, '0, 1'b0, 1'b1);
        force_match = 1'b1;
        rst = 1'b1;
        sb.delete();
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_ready_after_rst", in_rule_ready, 1'b1);
        seen = 0;
        for (int c = 0; c < 2 * L; c++) begin
            if (out_rule_valid) seen++;
            @(posedge clk); #1;
        end
        chk("t5_no_output", seen, 0);
        force_match = 1'b0;
        repeat (L + 2) begin @(posedge clk); #1; end

        // Statistics: 10 accepted, 4 hits
        for (int i = 0; i < 10; i++) begin
            send(16'h3000 + 16'(i), (i < 4) ? 8'h01 : 8'h02, '0, '0, 1'b0, i == 9);
        end
        drain("t6_drain");
`ifdef PMC_STATS_EN
        chk("t6_stat_in", stat_rules_in, 10);
        chk("t6_stat_hit", stat_rules_hit, 4);
`else
        chk("t6_stat_in", stat_rules_in, 0);
        chk("t6_stat_hit", stat_rules_hit, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/port_match_collector.md
# port_match_collector

Downstream consumer of the port-group unit. Accepts per-packet rule candidates, issues each candidate's port-group address with its ports to the port unit, and aligns the returned `port_match` with the rule ID through a fixed-latency delay line. Surviving rules and one end-of-packet marker per packet are buffered in a FIFO with valid/ready output. Because the port unit cannot be stalled, credit-based admission guarantees that no result is ever lost.

## Interface
Parameters:
- `RULE_WIDTH`, 16, rule ID width
- `PU_LATENCY`, 12, cycles from `pu_pg_valid` sampled high to `pu_port_match` valid
- `FIFO_DEPTH`, 32, output FIFO entries (power of two, ≥ 4)

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `in_rule_data`  in  RULE_WIDTH  candidate rule ID
- `in_rule_pg`  in  PG_AWIDTH  port-group address of the rule
- `in_src_port` / `in_dst_port`  in  16 each  packet ports
- `in_tcp`  in  1  packet protocol is TCP
- `in_rule_last`  in  1  last candidate of the packet
- `in_rule_valid`  in  1  candidate valid
- `in_rule_ready`  out  1  candidate accepted when valid & ready
- `pu_pg`  out  PG_AWIDTH  to port unit `in_pg`
- `pu_pg_valid`  out  1  to port unit `in_pg_valid`
- `pu_src_port` / `pu_dst_port`  out  16 each  to port unit
- `pu_tcp`  out  1  to port unit
- `pu_port_match`  in  1  from port unit
- `out_rule_data`  out  RULE_WIDTH  matched rule ID
- `out_rule_hit`  out  1  entry carries a matched rule
- `out_rule_last`  out  1  entry closes the packet
- `out_rule_valid`  out  1  FIFO head valid
- `out_rule_ready`  in  1  downstream pops on valid & ready
- `stat_rules_in` / `stat_rules_hit`  out  32 each  counters (see Configuration)

## Operation
- Accept: on `in_rule_valid & in_rule_ready`, register the issue fields. The next cycle, `pu_pg_valid`=1 with `pu_pg`/ports/tcp from the accepted beat. Otherwise `pu_pg_valid`=0 and the other `pu_*` outputs hold.
- Delay line: shift register of PU_LATENCY stages carrying {valid, rule, last}, loaded in parallel with `pu_pg_valid`. At the last stage, a valid slot samples `pu_port_match` in the same cycle.
- Push rule at the last stage when valid and (match or last). Entry = {rule, hit=match, last}.
  - hit=0, last=1 is an end-of-packet marker only.
  - Valid non-last slot with no match: nothing pushed.
- Credit:
  - `inflight` increments on accept and decrements whenever a valid slot leaves the last stage.
  - `in_rule_ready` = (`count` + `inflight`) < FIFO_DEPTH.
  - The counter widths hold FIFO_DEPTH + PU_LATENCY + 1.
- Simultaneous events: accept and retire in the same cycle leave `inflight` unchanged. Push and pop in the same cycle leave `count` unchanged. A push while full cannot occur; assert this in simulation.
- FIFO is show-ahead. Pop is legal only when `out_rule_valid`.
- Reset mid-operation clears the delay-line valids, `inflight`, FIFO pointers and counters. A stale `pu_port_match` from the un-reset port unit lands on invalid slots and is ignored.

## Timing
- Reset values: `in_rule_ready`=1 after reset releases, `pu_pg_valid`=0, `pu_pg`/`pu_*` ports=0, `out_rule_valid`=0, `out_rule_data`/`hit`/`last`=0, stats=0.
- Accept at edge T:
  - `pu_pg_valid` high in cycle T+1.
  - Match is sampled at T+1+PU_LATENCY.
  - FIFO write occurs at the same edge.
  - `out_rule_valid` is high at T+2+PU_LATENCY (14 with defaults) when the FIFO was empty.
- Throughput: one candidate per cycle while credit allows. With `out_rule_ready` held high, output throughput is one entry per cycle.
- `in_rule_ready` is registered-path only, with no combinational dependence on `in_rule_valid`.

## Configuration
- `PMC_STATS_EN` defined:
  - `stat_rules_in` increments per accepted candidate.
  - `stat_rules_hit` increments per push with hit=1.
  - Both are 32-bit and wrap; both clear on `rst`.
- `PMC_STATS_EN` undefined: both outputs are tied to 0 and no counter logic exists. The port list is identical in both builds.

## Structure
- Shared package (alongside `PG_AWIDTH`, `pg_entry_t`): `pmc_entry_t` {rule, hit, last} and the default `PMC_PU_LATENCY` = 12 constant, so the value stays tied to the port-unit pipeline depth.
- One sub-module, `pmc_fifo`:
  - Show-ahead synchronous FIFO of `pmc_entry_t`.
  - Exposes `count`.
  - Async active-high reset.
- The delay line and credit logic live in the top.

## Test plan
- Single rule, pg matches (port unit model returns 1): accept at T → `out_rule_valid` at T+14 with data=rule, hit=1, last=1.
- Packet of 3 rules, matches 0/1/0, last on the third: exactly two entries. First {rule1, hit=1, last=0}, then {rule2, hit=0, last=1}.
- Back-pressure: `out_rule_ready`=0 with continuous input, all matches. `in_rule_ready` drops once accepts reach 32. No push while full. Releasing ready drains all 32 entries in order.
- Accept and retire in the same cycle at the credit boundary: `inflight` constant and `in_rule_ready` stable, with no overflow or credit leak after 1000 random cycles.
- Assert `rst` with 5 rules in flight while the model keeps driving `pu_port_match`=1: no output appears after reset. `in_rule_ready`=1 on the cycle after release.
- With `PMC_STATS_EN`: 10 accepted, 4 hits → `stat_rules_in`=10, `stat_rules_hit`=4. Without the macro, both read 0.
